// File: rtl/synth_pkg.sv
// Types and constants shared across the synth voice path.
package synth_pkg;

    localparam int VA_KEY_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } va_state_t;

endpackage

// File: rtl/utils.sv
// Shared width helpers for parameterised blocks.
package utils;

    // Ceiling log2, with a floor of 1 so that a 1-entry table still gets a 1-bit index.
    function automatic int clogb2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/voice_lru_rank.sv
// Least-recently-allocated rank table: rank 0 is the newest allocation.
// Promoting a voice moves it to rank 0 and ages every voice that was newer than it.
module voice_lru_rank #(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = utils::clogb2(VOICES)
) (
    input  logic               data_clk,
    input  logic               reset_reg_N,
    input  logic [V_WIDTH-1:0] scan_idx,
    input  logic               promote,
    input  logic [V_WIDTH-1:0] promote_voice,
    output logic [V_WIDTH-1:0] scan_rank
);

    logic [V_WIDTH-1:0] rank [VOICES];
    logic [V_WIDTH-1:0] promote_rank;

    assign scan_rank    = rank[scan_idx];
    assign promote_rank = rank[promote_voice];

    // NOTE: the rank table is a small register file that must come out of reset as a
    // permutation, so unlike a data RAM every entry is reset explicitly.
    always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int v = 0; v < VOICES; v++) rank[v] <= V_WIDTH'(v);
        end else if (promote) begin
            for (int v = 0; v < VOICES; v++) begin
                if (V_WIDTH'(v) == promote_voice)
                    rank[v] <= '0;
                else if (rank[v] < promote_rank)
                    rank[v] <= rank[v] + V_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice scheduler: serially scans all voice slots for each MIDI note event, picks a
// target slot (retrigger > free > released > steal) and drives the engine note bus.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = utils::clogb2(VOICES)
) (
    input  logic               data_clk,
    input  logic               reset_reg_N,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_on,
    input  logic [7:0]         ev_key,
    input  logic [7:0]         ev_vel,
    input  logic [VOICES-1:0]  voice_free,
    output logic               note_on,
    output logic               ev_strobe,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off,
    output logic [VOICES-1:0]  keys_on,
    output logic [V_WIDTH:0]   active_keys,
    output logic               steal,
    output logic               off_note_error
);

    va_state_t             state;
    logic [V_WIDTH-1:0]    idx;
    logic                  ev_is_on_q;
    logic [VA_KEY_W-1:0]   ev_key_q;
    logic [7:0]            ev_vel_q;
    logic [VA_KEY_W-1:0]   key_tab [VOICES];

    logic                  hit_found, free_found, rel_found;
    logic [V_WIDTH-1:0]    hit_idx, free_idx, rel_idx, rel_rank, old_idx;

    logic [V_WIDTH-1:0]    scan_rank;
    logic [V_WIDTH-1:0]    target;
    logic                  take_steal;
    logic                  promote;
    logic [VOICES-1:0]     keys_on_next;
    logic [V_WIDTH:0]      key_count;
    logic                  key_match;
    logic                  unused_key_msb;

    assign unused_key_msb = ev_key[7];
    assign promote        = (state == ISSUE) && ev_is_on_q;
    assign key_match      = keys_on[idx] && (key_tab[idx] == ev_key_q);

    voice_lru_rank #(
        .VOICES  (VOICES),
        .V_WIDTH (V_WIDTH)
    ) u_rank (
        .data_clk      (data_clk),
        .reset_reg_N   (reset_reg_N),
        .scan_idx      (idx),
        .promote       (promote),
        .promote_voice (target),
        .scan_rank     (scan_rank)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        target     = old_idx;
        take_steal = 1'b0;
        if (!ev_is_on_q || hit_found) target = hit_idx;
        else if (free_found)          target = free_idx;
        else if (rel_found)           target = rel_idx;
        else                          take_steal = 1'b1;
    end

    always_comb begin
        keys_on_next = keys_on;
        if (state == ISSUE) begin
            if (ev_is_on_q)     keys_on_next[target] = 1'b1;
            else if (hit_found) keys_on_next[target] = 1'b0;
        end
    end

    always_comb begin
        key_count = '0;
        for (int v = 0; v < VOICES; v++) key_count = key_count + (V_WIDTH+1)'(keys_on_next[v]);
    end

    // NOTE: all state here is sequential and updated with non-blocking assignments, so
    // every branch reads the pre-edge values of the tables and trackers.
    always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state          <= IDLE;
            idx            <= '0;
            ev_is_on_q     <= 1'b0;
            ev_key_q       <= '0;
            ev_vel_q       <= '0;
            hit_found      <= 1'b0;
            free_found     <= 1'b0;
            rel_found      <= 1'b0;
            hit_idx        <= '0;
            free_idx       <= '0;
            rel_idx        <= '0;
            rel_rank       <= '0;
            old_idx        <= '0;
            ev_ready       <= 1'b1;
            note_on        <= 1'b0;
            ev_strobe      <= 1'b0;
            cur_key_adr    <= '0;
            cur_key_val    <= '0;
            cur_vel_on     <= '0;
            cur_vel_off    <= '0;
            keys_on        <= '0;
            active_keys    <= '0;
            steal          <= 1'b0;
            off_note_error <= 1'b0;
            for (int v = 0; v < VOICES; v++) key_tab[v] <= '0;
        end else begin
            ev_strobe      <= 1'b0;
            steal          <= 1'b0;
            off_note_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (!ev_ready) begin
                        ev_ready <= 1'b1;
                    end else if (ev_valid) begin
                        ev_ready   <= 1'b0;
                        ev_is_on_q <= ev_on && (ev_vel != 8'd0);
                        ev_key_q   <= ev_key[VA_KEY_W-1:0];
                        ev_vel_q   <= ev_vel;
                        idx        <= '0;
                        hit_found  <= 1'b0;
                        free_found <= 1'b0;
                        rel_found  <= 1'b0;
                        state      <= SCAN;
                    end
                end

                SCAN: begin
                    if (key_match && !hit_found) begin
                        hit_found <= 1'b1;
                        hit_idx   <= idx;
                    end
                    if (voice_free[idx] && !keys_on[idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (!keys_on[idx] && (!rel_found || scan_rank > rel_rank)) begin
                        rel_found <= 1'b1;
                        rel_idx   <= idx;
                        rel_rank  <= scan_rank;
                    end
                    // Ranks are a permutation, so exactly one voice carries the oldest rank.
                    if (scan_rank == V_WIDTH'(VOICES-1)) old_idx <= idx;
                    idx <= idx + V_WIDTH'(1);
                    if (idx == V_WIDTH'(VOICES-1)) state <= ISSUE;
                end

                ISSUE: begin
                    keys_on     <= keys_on_next;
                    active_keys <= key_count;
                    if (ev_is_on_q) begin
                        key_tab[target] <= ev_key_q;
                        cur_vel_on      <= ev_vel_q;
                        note_on         <= 1'b1;
                        cur_key_adr     <= target;
                        cur_key_val     <= {1'b0, ev_key_q};
                        ev_strobe       <= 1'b1;
                        steal           <= take_steal;
                    end else if (hit_found) begin
                        // A zero-velocity note-on lands here with ev_vel_q == 0.
                        cur_vel_off <= ev_vel_q;
                        note_on     <= 1'b0;
                        cur_key_adr <= target;
                        cur_key_val <= {1'b0, ev_key_q};
                        ev_strobe   <= 1'b1;
                    end else begin
                        off_note_error <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
